// File: rtl/pl_irq_collector.sv
// Sticky, maskable interrupt collector for periodic PL request lines with W1C register access.
// Optional per-channel saturating overrun counters: define IRQ_OVERRUN_CNT_EN.
module pl_irq_collector #(
    parameter int unsigned N_IRQ = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Sys_clk,
    input  logic             Rst,
    input  logic [N_IRQ-1:0] Irq_in,
    input  logic             Reg_wr_en,
    input  logic             Reg_rd_en,
    input  logic [3:0]       Reg_addr,
    input  logic [31:0]      Reg_wdata,
    output logic [31:0]      Reg_rdata,
    output logic             Reg_rd_valid,
    output logic             Irq_to_ps
);

    logic [N_IRQ-1:0] hist_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] overrun_q, overrun_d;
    logic [N_IRQ-1:0] rise, pend_w1c, ovr_w1c, ovr_set, active;
    logic [2:0]       id_idx;
    logic [31:0]      rdata_q, rdata_d;
    logic             rd_valid_q;
    logic             irq_q;
    logic             unused_wdata;

    assign unused_wdata = ^Reg_wdata;

    always_comb begin
        rise      = Irq_in & ~hist_q;
        pend_w1c  = (Reg_wr_en && Reg_addr == 4'h0) ? Reg_wdata[N_IRQ-1:0] : '0;
        ovr_w1c   = (Reg_wr_en && Reg_addr == 4'h2) ? Reg_wdata[N_IRQ-1:0] : '0;
        enable_d  = (Reg_wr_en && Reg_addr == 4'h1) ? Reg_wdata[N_IRQ-1:0] : enable_q;
        // A rise coinciding with W1C replaces the consumed event, so it is not an overrun.
        ovr_set   = rise & pending_q & ~pend_w1c;
        pending_d = (pending_q & ~pend_w1c) | rise;
        overrun_d = (overrun_q & ~ovr_w1c) | ovr_set;
        active    = pending_q & enable_q;
    end

    always_comb begin
        id_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) id_idx = 3'(i);
        end
    end

`ifdef IRQ_OVERRUN_CNT_EN
    logic [N_IRQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_IRQ; i++) begin
            if (Reg_wr_en && Reg_addr == 4'(i + 4)) begin
                cnt_d[i] = ovr_set[i] ? CNT_W'(1) : '0;
            end else if (ovr_set[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        case (Reg_addr)
            4'h0: rdata_d[N_IRQ-1:0] = pending_q;
            4'h1: rdata_d[N_IRQ-1:0] = enable_q;
            4'h2: rdata_d[N_IRQ-1:0] = overrun_q;
            4'h3: rdata_d = {|active, 28'b0, id_idx};
            default: begin
`ifdef IRQ_OVERRUN_CNT_EN
                for (int i = 0; i < N_IRQ; i++) begin
                    if (Reg_addr == 4'(i + 4)) rdata_d[CNT_W-1:0] = cnt_q[i];
                end
`endif
            end
        endcase
    end

    // hist resets to all ones so lines held high through reset produce no event.
    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            hist_q     <= '1;
            pending_q  <= '0;
            enable_q   <= '0;
            overrun_q  <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            hist_q     <= Irq_in;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= Reg_rd_en;
            irq_q      <= |active;
            if (Reg_rd_en) rdata_q <= rdata_d;
        end
    end

`ifdef IRQ_OVERRUN_CNT_EN
    always_ff @(posedge Sys_clk) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign Reg_rdata    = rdata_q;
    assign Reg_rd_valid = rd_valid_q;
    assign Irq_to_ps    = irq_q;

endmodule

// File: tb/tb_pl_irq_collector.sv
// Directed bench for pl_irq_collector; register reads are checked through an expected-value queue.
module tb_pl_irq_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  irq_in;
    logic        wr_en, rd_en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        irq_to_ps;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];

    pl_irq_collector #(.N_IRQ(2), .CNT_W(8)) dut (
        .Sys_clk     (clk),
        .Rst         (rst),
        .Irq_in      (irq_in),
        .Reg_wr_en   (wr_en),
        .Reg_rd_en   (rd_en),
        .Reg_addr    (addr),
        .Reg_wdata   (wdata),
        .Reg_rdata   (rdata),
        .Reg_rd_valid(rd_valid),
        .Irq_to_ps   (irq_to_ps)
    );

    always #5 clk = ~clk;

`ifdef IRQ_OVERRUN_CNT_EN
    localparam logic [31:0] CntOne = 32'd1;
    localparam logic [31:0] CntSat = 32'd255;
`else
    localparam logic [31:0] CntOne = 32'd0;
    localparam logic [31:0] CntSat = 32'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        rd_en = 1'b1;
        addr  = a;
        exp_q.push_back(e);
        tag_q.push_back(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse(input int b);
        irq_in[b] = 1'b1;
        tick();
        irq_in[b] = 1'b0;
        tick();
    endtask

    // Read-response checker: every Reg_rd_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL rd_unexpected: got rdata %h with no read outstanding", rdata);
            end
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                logic [3:0]  t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                vectors++;
                assert (rdata === e) else begin
                    miscompares++;
                    $error("FAIL rd_addr%0h: got %h expected %h", t, rdata, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; irq_in = 2'b11; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;

        // 1: lines high through reset create no events
        repeat (3) tick();
        @(negedge clk);
        chk("rst_irq", 32'(irq_to_ps), 0);
        chk("rst_rdvalid", 32'(rd_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("held_irq", 32'(irq_to_ps), 0);
        end
        tick();
        irq_in = 2'b00;
        rd(4'h0, 0);
        rd(4'h1, 0);
        rd(4'h2, 0);
        rd(4'h3, 0);
        rd(4'h9, 0);

        // 2: latency T -> pending T+1 -> irq T+2, and clear latency W -> W+2
        wr(4'h1, 3);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        @(negedge clk);
        chk("irq_t1", 32'(irq_to_ps), 0);
        rd(4'h0, 1);
        @(negedge clk);
        chk("irq_t2", 32'(irq_to_ps), 1);
        wr(4'h0, 1);
        @(negedge clk);
        chk("clr_w1", 32'(irq_to_ps), 1);
        tick();
        @(negedge clk);
        chk("clr_w2", 32'(irq_to_ps), 0);

        // 3: overrun flag and saturating counter
        irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
        repeat (9) tick();
        irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
        repeat (9) tick();
        rd(4'h0, 2);
        rd(4'h2, 2);
        rd(4'h5, CntOne);
        for (int i = 0; i < 300; i++) pulse(1);
        rd(4'h5, CntSat);
        rd(4'h4, 0);
        wr(4'h5, 0);
        rd(4'h5, 0);
        wr(4'h0, 3);
        wr(4'h2, 3);
        rd(4'h0, 0);
        rd(4'h2, 0);

        // 4: rise with W1C in the same cycle keeps pending, no overrun
        pulse(0);
        irq_in[0] = 1'b1;
        wr(4'h0, 1);
        irq_in[0] = 1'b0;
        tick();
        rd(4'h0, 1);
        rd(4'h2, 0);
        // overrun set beats overrun W1C in the same cycle
        irq_in[0] = 1'b1;
        wr(4'h2, 1);
        irq_in[0] = 1'b0;
        tick();
        rd(4'h2, 1);
        wr(4'h2, 1);
        rd(4'h2, 0);

        // 5: ID register and masking
        pulse(1);
        rd(4'h0, 3);
        wr(4'h1, 2);
        rd(4'h3, 32'h8000_0001);
        wr(4'h1, 0);
        rd(4'h3, 0);
        @(negedge clk);
        chk("masked_irq", 32'(irq_to_ps), 0);
        rd(4'h0, 3);

        // 6: reset with pending, overrun and a read in flight
        pulse(0);
        rd(4'h2, 1);
        tick();
        rst = 1'b1;
        rd_en = 1'b1;
        addr = 4'h0;
        tick();
        rst = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        chk("rst6_rdvalid", 32'(rd_valid), 0);
        chk("rst6_irq", 32'(irq_to_ps), 0);
        chk("rst6_rdata", rdata, 0);
        tick();
        rd(4'h0, 0);
        rd(4'h1, 0);
        rd(4'h2, 0);
        rd(4'h3, 0);
        rd(4'h5, 0);

        repeat (3) tick();
        chk("rd_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
